// File: rtl/rng_card_dealer.sv
// rtl/rng_card_dealer.sv - deals source cards round-robin into hands and keeps per-hand point totals
module rng_card_dealer #(
   parameter int NUM_PLAYERS      = 4,
   parameter int CARDS_PER_PLAYER = 2,
   parameter int TIMEOUT_CYCLES   = 16,
   parameter int MAX_RETRY        = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     deal_start_i,
   output logic                     request_card_o,
   input  logic [7:0]               card_i,
   input  logic                     card_valid_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic                     dealt_valid_o,
   output logic [7:0]               dealt_card_o,
   output logic [2:0]               dealt_player_o,
   output logic [2:0]               dealt_slot_o,
   output logic [8*NUM_PLAYERS-1:0] totals_o
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int RW = $clog2(MAX_RETRY + 1);
   // WAIT gives up on the edge where the counter would reach TIMEOUT_CYCLES-1,
   // so the retry request lands exactly TIMEOUT_CYCLES cycles after the previous one.
   localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [2:0]    LAST_PLAYER = 3'(NUM_PLAYERS - 1);
   localparam logic [2:0]    LAST_SLOT   = 3'(CARDS_PER_PLAYER - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t          state_q;
   logic            request_q, busy_q, done_q, error_q, dealt_valid_q;
   logic [7:0]      dealt_card_q;
   logic [2:0]      dealt_player_q, dealt_slot_q;
   logic [2:0]      player_q, slot_q;
   logic [TW-1:0]   tmo_q;
   logic [RW-1:0]   retry_q;
   logic [7:0]      totals_q [NUM_PLAYERS];

   logic [3:0]      rank;
   logic            rank_ok;
   logic            last_card;
   logic [RW-1:0]   retry_d;
   logic [7:0]      points_d;

   // Card decode: legality, point value and end-of-deal detection
   always_comb begin
      rank      = card_i[3:0];
      rank_ok   = (rank != 4'd0) && (rank <= 4'd13);
      points_d  = (rank > 4'd10) ? 8'd10 : {4'd0, rank};
      retry_d   = retry_q + 1'b1;
      last_card = (player_q == LAST_PLAYER) && (slot_q == LAST_SLOT);
   end

   // Deal FSM with registered outputs, hand position, retry and timeout tracking
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         request_q      <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         dealt_valid_q  <= 1'b0;
         dealt_card_q   <= 8'd0;
         dealt_player_q <= 3'd0;
         dealt_slot_q   <= 3'd0;
         player_q       <= 3'd0;
         slot_q         <= 3'd0;
         tmo_q          <= '0;
         retry_q        <= '0;
         for (int p = 0; p < NUM_PLAYERS; p++) totals_q[p] <= 8'd0;
      end else begin
         request_q     <= 1'b0;
         done_q        <= 1'b0;
         dealt_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (deal_start_i) begin
                  state_q        <= REQ;
                  request_q      <= 1'b1;
                  busy_q         <= 1'b1;
                  error_q        <= 1'b0;
                  dealt_card_q   <= 8'd0;
                  dealt_player_q <= 3'd0;
                  dealt_slot_q   <= 3'd0;
                  player_q       <= 3'd0;
                  slot_q         <= 3'd0;
                  retry_q        <= '0;
                  for (int p = 0; p < NUM_PLAYERS; p++) totals_q[p] <= 8'd0;
               end
            end
            REQ: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               tmo_q <= tmo_q + 1'b1;
               if (card_valid_i && rank_ok) begin
                  dealt_valid_q  <= 1'b1;
                  dealt_card_q   <= card_i;
                  dealt_player_q <= player_q;
                  dealt_slot_q   <= slot_q;
                  retry_q        <= '0;
                  for (int p = 0; p < NUM_PLAYERS; p++)
                     if (player_q == 3'(p)) totals_q[p] <= totals_q[p] + points_d;
                  if (player_q == LAST_PLAYER) begin
                     player_q <= 3'd0;
                     slot_q   <= slot_q + 3'd1;
                  end else begin
                     player_q <= player_q + 3'd1;
                  end
                  if (last_card) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q   <= REQ;
                     request_q <= 1'b1;
                  end
               end else if (card_valid_i || (tmo_q == TMO_LAST)) begin
                  retry_q <= retry_d;
                  if (retry_d == RETRY_LIMIT) begin
                     state_q <= IDLE;
                     error_q <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q   <= REQ;
                     request_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign request_card_o = request_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign error_o        = error_q;
   assign dealt_valid_o  = dealt_valid_q;
   assign dealt_card_o   = dealt_card_q;
   assign dealt_player_o = dealt_player_q;
   assign dealt_slot_o   = dealt_slot_q;

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_totals
      assign totals_o[8*g +: 8] = totals_q[g];
   end

endmodule

// File: tb/tb_rng_card_dealer.sv
// tb/tb_rng_card_dealer.sv - directed table-driven bench for rng_card_dealer
module tb_rng_card_dealer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        deal_start_i = 1'b0;
   logic        request_card_o;
   logic [7:0]  card_i = 8'd0;
   logic        card_valid_i = 1'b0;
   logic        busy_o, done_o, error_o, dealt_valid_o;
   logic [7:0]  dealt_card_o;
   logic [2:0]  dealt_player_o, dealt_slot_o;
   logic [31:0] totals_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] card;
      logic [2:0] player;
      logic [2:0] slot;
      logic [7:0] total;
      logic       done;
   } vec_t;

   vec_t vecs [16];

   rng_card_dealer dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .deal_start_i   (deal_start_i),
      .request_card_o (request_card_o),
      .card_i         (card_i),
      .card_valid_i   (card_valid_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .error_o        (error_o),
      .dealt_valid_o  (dealt_valid_o),
      .dealt_card_o   (dealt_card_o),
      .dealt_player_o (dealt_player_o),
      .dealt_slot_o   (dealt_slot_o),
      .totals_o       (totals_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick();
      @(negedge clk_i);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_req"},     {31'd0, request_card_o}, 0);
      check({tag, "_busy"},    {31'd0, busy_o}, 0);
      check({tag, "_done"},    {31'd0, done_o}, 0);
      check({tag, "_err"},     {31'd0, error_o}, 0);
      check({tag, "_dvalid"},  {31'd0, dealt_valid_o}, 0);
      check({tag, "_dcard"},   {24'd0, dealt_card_o}, 0);
      check({tag, "_dplayer"}, {29'd0, dealt_player_o}, 0);
      check({tag, "_dslot"},   {29'd0, dealt_slot_o}, 0);
      check({tag, "_totals"},  totals_o, 0);
   endtask

   task automatic start_deal();
      deal_start_i = 1'b1;
      tick();
      deal_start_i = 1'b0;
      check("start_req",  {31'd0, request_card_o}, 1);
      check("start_busy", {31'd0, busy_o}, 1);
      check("start_err",  {31'd0, error_o}, 0);
   endtask

   task automatic wait_req();
      int n = 0;
      while (request_card_o !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
      check("req_wait", {31'd0, request_card_o}, 1);
   endtask

   // Called at the request cycle; presents the card dly cycles later for one cycle.
   task automatic give_card(input logic [7:0] card, input int dly);
      repeat (dly) tick();
      card_valid_i = 1'b1;
      card_i       = card;
      tick();
      card_valid_i = 1'b0;
   endtask

   task automatic deal_card(input logic [7:0] card, input int dly, input logic [2:0] p,
                            input logic [2:0] s, input logic [7:0] tot, input logic dn);
      wait_req();
      give_card(card, dly);
      check("dvalid",  {31'd0, dealt_valid_o}, 1);
      check("dcard",   {24'd0, dealt_card_o}, {24'd0, card});
      check("dplayer", {29'd0, dealt_player_o}, {29'd0, p});
      check("dslot",   {29'd0, dealt_slot_o}, {29'd0, s});
      check("dtotal",  {24'd0, totals_o[8*p +: 8]}, {24'd0, tot});
      check("ddone",   {31'd0, done_o}, {31'd0, dn});
      check("dnextreq", {31'd0, request_card_o}, {31'd0, ~dn});
      check("dbusy",   {31'd0, busy_o}, 1);
      if (dn) begin
         tick();
         check("end_busy",   {31'd0, busy_o}, 0);
         check("end_done",   {31'd0, done_o}, 0);
         check("end_dvalid", {31'd0, dealt_valid_o}, 0);
         check("end_hold",   {24'd0, dealt_card_o}, {24'd0, card});
      end
   endtask

   initial begin
      int gap;
      int reqs;
      logic done_seen;

      vecs[0]  = '{8'h01, 3'd0, 3'd0, 8'd1,  1'b0};
      vecs[1]  = '{8'h02, 3'd1, 3'd0, 8'd2,  1'b0};
      vecs[2]  = '{8'h03, 3'd2, 3'd0, 8'd3,  1'b0};
      vecs[3]  = '{8'h04, 3'd3, 3'd0, 8'd4,  1'b0};
      vecs[4]  = '{8'h05, 3'd0, 3'd1, 8'd6,  1'b0};
      vecs[5]  = '{8'h06, 3'd1, 3'd1, 8'd8,  1'b0};
      vecs[6]  = '{8'h07, 3'd2, 3'd1, 8'd10, 1'b0};
      vecs[7]  = '{8'h08, 3'd3, 3'd1, 8'd12, 1'b1};
      vecs[8]  = '{8'h3D, 3'd0, 3'd0, 8'd10, 1'b0};
      vecs[9]  = '{8'h2C, 3'd1, 3'd0, 8'd10, 1'b0};
      vecs[10] = '{8'h1B, 3'd2, 3'd0, 8'd10, 1'b0};
      vecs[11] = '{8'h01, 3'd3, 3'd0, 8'd1,  1'b0};
      vecs[12] = '{8'hCA, 3'd0, 3'd1, 8'd20, 1'b0};
      vecs[13] = '{8'h12, 3'd1, 3'd1, 8'd12, 1'b0};
      vecs[14] = '{8'h23, 3'd2, 3'd1, 8'd13, 1'b0};
      vecs[15] = '{8'h34, 3'd3, 3'd1, 8'd5,  1'b1};

      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
      check_idle_outputs("rst");

      // card_valid in IDLE must be ignored
      card_valid_i = 1'b1;
      card_i       = 8'h05;
      tick();
      tick();
      card_valid_i = 1'b0;
      check("idle_dvalid", {31'd0, dealt_valid_o}, 0);
      check("idle_busy",   {31'd0, busy_o}, 0);
      check("idle_req",    {31'd0, request_card_o}, 0);

      // Default deal and face-card deal from the table
      for (int i = 0; i < 16; i++) begin
         if (i % 8 == 0) start_deal();
         deal_card(vecs[i].card, 2, vecs[i].player, vecs[i].slot, vecs[i].total, vecs[i].done);
         if (i == 7)  check("totals_a", totals_o, 32'h0C0A_0806);
         if (i == 11) check("totals_face", totals_o, 32'h010A_0A0A);
         if (i == 15) check("totals_b", totals_o, 32'h050D_0C14);
      end

      // Ignored inputs in REQ, then first request times out
      start_deal();
      check("clear_totals", totals_o, 0);
      card_valid_i = 1'b1;
      card_i       = 8'h05;
      deal_start_i = 1'b1;
      tick();
      card_valid_i = 1'b0;
      deal_start_i = 1'b0;
      check("req_ign_dvalid", {31'd0, dealt_valid_o}, 0);
      check("req_ign_req",    {31'd0, request_card_o}, 0);
      gap = 1;
      while (request_card_o !== 1'b1 && gap < 40) begin
         tick();
         gap++;
      end
      check("timeout_gap", gap, 16);
      check("timeout_err", {31'd0, error_o}, 0);
      deal_card(8'h09, 1, 3'd0, 3'd0, 8'd9, 1'b0);
      deal_card(8'h07, 1, 3'd1, 3'd0, 8'd7, 1'b0);
      deal_card(8'h0B, 1, 3'd2, 3'd0, 8'd10, 1'b0);

      // Reset mid-deal
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_idle_outputs("midrst");
      tick();
      check("midrst_req2", {31'd0, request_card_o}, 0);

      // Fresh deal: one illegal rank is discarded and re-requested
      start_deal();
      give_card(8'h0E, 1);
      check("illegal_dvalid", {31'd0, dealt_valid_o}, 0);
      check("illegal_rereq",  {31'd0, request_card_o}, 1);
      for (int i = 0; i < 8; i++)
         deal_card(vecs[i].card, 1, vecs[i].player, vecs[i].slot, vecs[i].total, vecs[i].done);

      // Abort: the source never answers
      start_deal();
      reqs = 1;
      done_seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         tick();
         if (request_card_o) reqs++;
         if (done_o) done_seen = 1'b1;
      end
      check("abort_reqs", reqs, 3);
      check("abort_err",  {31'd0, error_o}, 1);
      check("abort_busy", {31'd0, busy_o}, 0);
      check("abort_done", {31'd0, done_seen}, 0);

      // Next accepted start clears the sticky error
      start_deal();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_idle_outputs("final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rng_card_dealer.md
Name: rng_card_dealer

Overview:
- Consumer at the far end of the card-request interface: issues single-cycle card requests to the de-duplicating card source and accepts each returned 8-bit card.
- Deals the cards round-robin into NUM_PLAYERS hands of CARDS_PER_PLAYER cards each.
- Keeps a running point total per hand.
- Sits between the card source and game-control logic, which starts a deal and reads the hands and totals.

Parameters:
- NUM_PLAYERS, 4, number of hands dealt; legal range 1..8.
- CARDS_PER_PLAYER, 2, cards per hand; legal range 1..8.
- TIMEOUT_CYCLES, 16, cycles waited in WAIT for card_valid_i before one retry; minimum 2.
- MAX_RETRY, 3, consecutive failed attempts (timeout or illegal card) allowed per card before abort.

Ports:
- clk_i  input  1  single clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- deal_start_i  input  1  pulse; begins a deal when the block is idle.
- request_card_o  output  1  single-cycle request to the card source.
- card_i  input  8  card from the source: [3:0] rank, [5:4] suit, [7:6] ignored.
- card_valid_i  input  1  card_i is valid this cycle.
- busy_o  output  1  a deal is in progress.
- done_o  output  1  one-cycle pulse; the deal completed successfully.
- error_o  output  1  sticky abort flag; cleared by the next accepted deal_start_i or by reset.
- dealt_valid_o  output  1  one-cycle pulse; dealt_* fields are valid.
- dealt_card_o  output  8  the accepted card, exactly as received.
- dealt_player_o  output  3  hand index, 0..NUM_PLAYERS-1.
- dealt_slot_o  output  3  position within the hand, 0..CARDS_PER_PLAYER-1.
- totals_o  output  8*NUM_PLAYERS  per-hand point totals; hand p occupies bits [8p+7:8p].

Behaviour:
- Reset: state IDLE. All outputs 0. All totals, counters and retry counts cleared.
- Reset mid-deal abandons the deal immediately; no done_o, error_o = 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - deal_start_i = 1 at an edge → REQ.
  - On that edge: clear totals, card index k, retry count and error_o; set busy_o = 1.
  - card_valid_i is ignored in IDLE.
- REQ:
  - request_card_o = 1 for exactly this one cycle (Moore output).
  - Timeout counter cleared; → WAIT.
  - First request_card_o is high in the cycle after deal_start_i is sampled.
- WAIT:
  - Timeout counter increments every cycle.
  - card_valid_i = 1 with a legal rank (1..13) → accept the card.
  - card_valid_i = 1 with rank 0 or 14..15 → failed attempt; card discarded, no dealt_valid_o.
  - Counter reaches TIMEOUT_CYCLES-1 with no valid → failed attempt.
  - If card_valid_i arrives on the timeout cycle, the card wins.
- Failed attempt:
  - retry count += 1.
  - If the new count == MAX_RETRY → error_o = 1, busy_o = 0, → IDLE (no done_o).
  - Otherwise → REQ.
- Accept on the edge:
  - dealt_valid_o = 1 for one cycle; dealt_card_o = card_i.
  - dealt_player_o = k mod NUM_PLAYERS; dealt_slot_o = k / NUM_PLAYERS.
  - Totals of that player += point value.
  - k += 1; retry count cleared.
  - Next state is DONE if k was NUM_PLAYERS*CARDS_PER_PLAYER-1, else REQ.
- Point value: rank 1 = 1; ranks 2..10 = rank; ranks 11..13 = 10. Totals are unsigned 8-bit; the maximum is 80, so they never overflow.
- Per-card accept-to-next-request latency is 1 cycle: dealt_valid_o and request_card_o are high in the same cycle.
- DONE: done_o = 1 for one cycle, coinciding with dealt_valid_o of the last card. busy_o drops when DONE is left; → IDLE.
- deal_start_i while busy_o = 1 is ignored.
- card_valid_i in REQ, DONE or IDLE is ignored; no stray acceptance.
- dealt_* fields and totals_o hold their values after the deal until the next accepted deal_start_i or reset.

Test Plan:
- Defaults. Pulse deal_start_i; source answers each request 2 cycles later with ranks 1,2,...,8 (suit 0).
  - Required: 8 dealt_valid_o pulses; players 0,1,2,3,0,1,2,3; slots 0,0,0,0,1,1,1,1.
  - Required: totals = {12,10,8,6} for players 3..0; done_o once with the 8th dealt_valid_o; busy_o low the next cycle.
- Face cards. Deliver ranks 13,12,11,1 to players 0..3 in round 1.
  - Required after round 1: totals 10,10,10,1.
- Timeout. Source ignores the first request.
  - Required: request_card_o re-pulses 16 cycles after the first.
  - Required: a card delivered after the second request is accepted normally.
- Abort. Source never answers (or returns rank 0 three times).
  - Required: exactly 3 request pulses; then error_o = 1, busy_o = 0, no done_o.
  - Required: the next deal_start_i clears error_o.
- Ignored inputs. Assert deal_start_i mid-deal, and card_valid_i in REQ and IDLE.
  - Required: no restart, no extra dealt_valid_o, card count unchanged.
- Reset mid-deal. Assert rst_i after 3 cards.
  - Required next cycle: all outputs 0, totals 0, state IDLE; a fresh deal then completes with player 0 slot 0 first.
